// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative shift-add multiply / restoring divide into HI/LO registers.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic is_div, sa, sb, dz;
  logic [WIDTH-1:0] opd, acc_hi, acc_lo, a_raw, abs_a, abs_b, quo, rem;
  logic [WIDTH:0] mul_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    abs_a = (!op[0] && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    abs_b = (!op[0] && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff = shifted - {1'b0, opd};
    prod = (sa ^ sb) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo = dz ? '1 : (sa ^ sb) ? -acc_lo : acc_lo;
    rem = dz ? a_raw : sa ? -acc_hi : acc_hi;
  end
  // acc_hi/acc_lo hold partial product (mul) or remainder/quotient (div)
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      opd    <= '0;
      a_raw  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            sa     <= !op[0] && rs_val[WIDTH-1];
            sb     <= !op[0] && rt_val[WIDTH-1];
            dz     <= op[1] && (rt_val == '0);
            a_raw  <= rs_val;
            opd    <= op[1] ? abs_b : abs_a;
            acc_hi <= '0;
            acc_lo <= op[1] ? abs_a : abs_b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            if (mthi) hi <= rs_val;
            if (mtlo) lo <= rs_val;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], !diff[WIDTH]};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= is_div ? {rem, quo} : prod;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
